// File: rtl/xor_stream_ctrl.sv
// -----------------------------------------------------------------------------
// xor_stream_ctrl
//   Sequencing controller for the XOR encryption datapath. A multi-byte key is
//   loaded over a byte port. Payload bytes are then streamed through
//   out = in ^ key[idx] using valid/ready handshakes, and the key index cycles
//   through the key.
//
//   Optional feature macro: XOR_LFSR_KEYSTREAM_EN
//     When defined, an 8-bit LFSR is XORed into the keystream. The LFSR is
//     seeded to 0x01 on reset and on RUN entry, and it advances on every
//     accepted byte.
//
// Parameters
//   KEY_LEN     number of key bytes (2..16)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   ena         tile enable; when low all non-reset updates freeze
//   cmd_load    IDLE: start key load
//   cmd_start   IDLE: enter RUN (only once a full key has been loaded)
//   cmd_stop    RUN: return to IDLE
//   key_in      key byte, qualified by key_valid while in LOAD
//   key_valid   qualifies key_in
//   in_data     payload byte
//   in_valid    payload valid
//   in_ready    controller accepts payload
//   out_data    encrypted byte (registered)
//   out_valid   out_data valid
//   out_ready   downstream accepts
//   state       00 IDLE, 01 LOAD, 10 RUN
//   key_loaded  a full key has been loaded since reset
// -----------------------------------------------------------------------------
module xor_stream_ctrl #(
   parameter int KEY_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       cmd_load,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic [7:0] key_in,
   input  logic       key_valid,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] state,
   output logic       key_loaded
);

   localparam int              IDX_W    = (KEY_LEN > 2) ? $clog2(KEY_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       key_q [KEY_LEN];
   logic             key_loaded_q;
   logic             out_valid_q;
   logic [7:0]       out_data_q;
   logic [7:0]       ks;
   logic             accept;
   logic             pop;
   logic             run_entry;

   // Load has priority over start, and start needs a complete key.
   assign run_entry = (state_q == S_IDLE) && !cmd_load && cmd_start && key_loaded_q;
   assign accept    = in_valid && in_ready;
   // A pop is legal in any state, so a byte pending at stop can drain in IDLE.
   assign pop       = out_valid && out_ready;

`ifdef XOR_LFSR_KEYSTREAM_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= 8'h01;
      end else if (ena) begin
         if (run_entry)
            lfsr_q <= 8'h01;
         else if (accept)
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign ks = key_q[idx_q] ^ lfsr_q;
`else
   assign ks = key_q[idx_q];
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else if (ena)
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_load)
               state_d = S_LOAD;
            else if (run_entry)
               state_d = S_RUN;
         end
         S_LOAD: begin
            if (key_valid && (idx_q == LAST_IDX))
               state_d = S_IDLE;
         end
         S_RUN: begin
            if (cmd_stop)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs; ena low masks the handshake outputs without touching registers
   always_comb begin
      in_ready  = 1'b0;
      out_valid = ena && out_valid_q;
      if (ena && (state_q == S_RUN))
         in_ready = !out_valid_q || out_ready;
   end

   assign out_data   = out_data_q;
   assign state      = state_q;
   assign key_loaded = key_loaded_q;

   // Key storage, index and registered output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q        <= '0;
         key_loaded_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'h00;
         for (int i = 0; i < KEY_LEN; i++)
            key_q[i] <= 8'h00;
      end else if (ena) begin
         unique case (state_q)
            S_IDLE: begin
               if (cmd_load || run_entry)
                  idx_q <= '0;
            end
            S_LOAD: begin
               if (key_valid) begin
                  key_q[idx_q] <= key_in;
                  if (idx_q == LAST_IDX) begin
                     idx_q        <= '0;
                     key_loaded_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_ONE;
                  end
               end
            end
            S_RUN: begin
               // Stop rewinds the index even if a byte is accepted in that cycle.
               if (cmd_stop)
                  idx_q <= '0;
               else if (accept)
                  idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
            end
            default: idx_q <= '0;
         endcase

         // An accept together with a pop replaces the byte with no bubble.
         if (accept) begin
            out_data_q  <= in_data ^ ks;
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/xor_stream_ctrl.md
# xor_stream_ctrl

Sequencing controller for the XOR encryption datapath of the `tt_um_xor_encryption` tile. It loads a multi-byte key over a byte port, then streams payload bytes through `data ^ key[idx]` with valid/ready handshakes, cycling the key index. It sits between the tile pin mux and the output register and owns all mode and state sequencing.

## Interface

Parameters:
- `KEY_LEN`, default 4: number of key bytes; legal range 2..16; need not be a power of two.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: tile enable; when low, all non-reset register updates freeze.
- `cmd_load` in 1: in IDLE, start key load.
- `cmd_start` in 1: in IDLE, enter RUN.
- `cmd_stop` in 1: in RUN, return to IDLE.
- `key_in` in 8: key byte.
- `key_valid` in 1: qualifies `key_in` in LOAD.
- `in_data` in 8: payload byte.
- `in_valid` in 1: payload valid.
- `in_ready` out 1: controller accepts payload.
- `out_data` out 8: encrypted byte.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts.
- `state` out 2: 00 IDLE, 01 LOAD, 10 RUN.
- `key_loaded` out 1: a full key has been loaded since reset.

## Operation

- **Reset** (`rst_n`=0 at an edge):
  - state IDLE, index 0, all key bytes 0x00.
  - `key_loaded` 0, `out_valid` 0, `out_data` 0x00.
  - `in_ready` 0; LFSR 0x01 (when configured).
- **IDLE**:
  - `in_ready`=0.
  - `cmd_load` → LOAD with index 0.
  - `cmd_start` → RUN with index 0 (and LFSR 0x01) only if `key_loaded`=1; otherwise ignored.
  - `cmd_load` and `cmd_start` in the same cycle: load wins.
  - `cmd_stop` is ignored.
- **LOAD**:
  - Each cycle with `key_valid`=1 writes `key[index]` and increments the index.
  - The cycle that writes `key[KEY_LEN-1]` sets `key_loaded`=1, sets index to 0, and moves to IDLE.
  - All `cmd_*` are ignored. `in_ready`=0.
  - A partial load leaves `key_loaded` unchanged, so a previous full key keeps its flag.
- **RUN**:
  - `in_ready` = !`out_valid` || `out_ready`.
  - Accept (`in_valid` && `in_ready`):
    - `out_data` <= `in_data` ^ ks, where ks = `key[index]`.
    - `out_valid` <= 1.
    - index <= (index == KEY_LEN-1) ? 0 : index+1.
  - Pop (`out_valid` && `out_ready`) with no accept in the same cycle: `out_valid` <= 0.
  - Pop and accept in the same cycle: the new byte replaces the old one, with no bubble.
- **Stop**:
  - `cmd_stop` in RUN → IDLE next cycle and index is set to 0.
  - A transfer in the stop cycle is still accepted.
  - A pending `out_valid` is held until popped; the pop is legal in IDLE.
- **`ena`=0**:
  - `in_ready` and `out_valid` are forced to 0 combinationally.
  - No register changes except by reset; state resumes unchanged when `ena` returns to 1.

## Timing

- Command to `state` change: 1 cycle.
- Accepted input to `out_valid`/`out_data`: 1 cycle (registered output).
- Throughput: 1 byte/cycle while `out_ready`=1.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Index wraps from KEY_LEN-1 to 0 on the accept that consumes the last key byte.
- Reset mid-LOAD or mid-RUN:
  - The next cycle is IDLE with `key_loaded`=0.
  - Any pending output is discarded.

## Configuration

- `XOR_LFSR_KEYSTREAM_EN`: adds an 8-bit LFSR keystream.
- **Defined**:
  - ks = `key[index]` ^ lfsr.
  - lfsr is set to 0x01 on RUN entry and on reset.
  - lfsr advances on each accepted byte: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - lfsr holds on `cmd_stop`, but is re-seeded on the next start.
- **Undefined**: ks = `key[index]`; no LFSR registers are present.

## Test plan

1. **Reset**: apply reset for 2 cycles → `state`=00, `out_valid`=0, `out_data`=0x00, `in_ready`=0, `key_loaded`=0.
2. **Basic stream**: KEY_LEN=4; load 0x12,0x34,0x56,0x78; `cmd_start`; feed 0x00,0x00,0x00,0x00,0xFF with `out_ready`=1 → outputs 0x12,0x34,0x56,0x78,0xED, 1-cycle latency, back-to-back.
   - With `XOR_LFSR_KEYSTREAM_EN`, the first four outputs are 0x13,0x36,0x52,0x70.
3. **Backpressure**: hold `out_ready`=0 after the first output → `in_ready`=0 and `out_data` is held; release → the remaining bytes arrive in order with no loss or duplication.
4. **Start without key**: `cmd_start` before any full load → `state` stays 00 and `in_ready` stays 0.
5. **Stop and restart**: `cmd_stop` after 2 bytes, then `cmd_start`, then feed 0x00 → output 0x12 (index restarted at 0).
6. **Reset mid-load**: reset after 2 of 4 key bytes → `key_loaded`=0 and a following `cmd_start` is ignored; `ena`=0 during RUN → `in_ready`=0 and `out_valid`=0, and the index is unchanged when `ena` returns.
